// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I access-size
// encodings, FSM state encoding and the alignment rule.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Byte accesses are always aligned; halfwords need bit 0 clear,
    // words need both low bits clear.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = (lo[0] == 1'b0);
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it to XLEN bits.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] value_o
);

    logic [XLEN-1:0] shifted;
    logic [15:0]     half;

    // Lane select followed by extension according to the access type.
    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        half    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    value_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    value_o = {{16{half[15]}}, half};
            F3_BU:   value_o = {24'd0, shifted[7:0]};
            F3_HU:   value_o = {16'd0, half};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one valid/ready memory request per
// load/store, stalls the core until it completes and returns the extended
// load value to the write-back mux.
//
// state   | meaning
// IDLE    | no access in flight; a legal request stalls and is latched here
// REQ     | mem_req_valid asserted, request fields held until ready
// WAIT    | load accepted, waiting for mem_rsp_valid
// DONE    | stall released for one cycle so the core advances
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       D_in,
    output logic              stall,
    output logic              lsu_fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              mem_we_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic [31:0]       d_in_q;

    logic              is_req;
    logic              f3_legal;
    logic              req_ok;
    logic              accept;
    logic              load_done;
    logic [31:0]       wdata_fmt;
    logic [3:0]        wstrb_fmt;
    logic [31:0]       load_value;

    // Request decode: a store wins when both request lines are high.
    always_comb begin
        is_req = req_load | req_store;
        if (req_store) begin
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        req_ok = is_req & f3_legal & addr_aligned(funct3, addr[1:0]);
    end

    // Store lane formatting; reads carry no byte enables.
    always_comb begin
        wdata_fmt = 32'd0;
        wstrb_fmt = 4'd0;
        if (req_store) begin
            case (funct3)
                F3_B: begin
                    wdata_fmt = {4{store_data[7:0]}};
                    wstrb_fmt = 4'b0001 << addr[1:0];
                end
                F3_H: begin
                    wdata_fmt = {2{store_data[15:0]}};
                    wstrb_fmt = 4'b0011 << {addr[1], 1'b0};
                end
                default: begin
                    wdata_fmt = store_data;
                    wstrb_fmt = 4'b1111;
                end
            endcase
        end
    end

    // Next-state and handshake/stall outputs.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        lsu_fault     = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        load_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_req) begin
                    if (req_ok) begin
                        stall   = 1'b1;
                        accept  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        lsu_fault = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = mem_we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    load_done = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields latched on acceptance; load result captured on response.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_we_q    <= 1'b0;
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
            d_in_q      <= 32'd0;
        end else begin
            if (accept) begin
                mem_addr_q  <= MEM_AW'({addr[31:2], 2'b00});
                mem_wdata_q <= wdata_fmt;
                mem_wstrb_q <= wstrb_fmt;
                mem_we_q    <= req_store;
                addr_lo_q   <= addr[1:0];
                funct3_q    <= funct3;
            end
            if (load_done) begin
                d_in_q <= load_value;
            end
        end
    end

    lsu_load_extract u_extract (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .value_o   (load_value)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_we    = mem_we_q;
    assign D_in      = d_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of access vectors with a
// cycle-level memory responder, a scoreboard queue of expected load results,
// and hand-written reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_load, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] D_in;
    logic        stall, lsu_fault;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_load      (req_load),
        .req_store     (req_store),
        .funct3        (funct3),
        .addr          (addr),
        .store_data    (store_data),
        .D_in          (D_in),
        .stall         (stall),
        .lsu_fault     (lsu_fault),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        logic        fault;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] din;
        int          stall_cyc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] din_model;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int valid_cnt;
        int stall_cnt;
        int rsp_at;
        bit done;
        logic [31:0] e;
        valid_cnt = 0;
        stall_cnt = 0;
        rsp_at    = -1;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_load   = v.ld;
                req_store  = v.st;
                funct3     = v.f3;
                addr       = v.addr;
                store_data = v.sdata;
            end
            mem_req_ready = (valid_cnt >= v.rdy_dly);
            mem_rsp_valid = (c == rsp_at);
            mem_rdata     = (c == rsp_at) ? v.rdata : ~v.rdata;
            if (c == rsp_at) exp_q.push_back(v.din);
            #1;
            check32($sformatf("v%0d fault c%0d", idx, c), 32'(lsu_fault), (c == 0) ? 32'(v.fault) : 32'd0);
            if (mem_req_valid) begin
                valid_cnt++;
                check32($sformatf("v%0d mem_addr", idx), mem_addr, v.maddr);
                check32($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
                check32($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.wstrb));
                if (v.we) check32($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
                if (mem_req_ready && !v.we) rsp_at = c + 1 + v.rsp_dly;
            end
            if (stall) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                check32($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.stall_cyc));
                check32($sformatf("v%0d req_cycles", idx), 32'(valid_cnt),
                        v.fault ? 32'd0 : 32'(v.rdy_dly + 1));
                if (!v.fault && v.ld && !v.st) begin
                    if (exp_q.size() == 0) begin
                        check32($sformatf("v%0d no_response", idx), 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check32($sformatf("v%0d D_in", idx), D_in, e);
                        din_model = e;
                    end
                end else begin
                    check32($sformatf("v%0d D_in_hold", idx), D_in, din_model);
                end
            end
        end
        if (!done) check32($sformatf("v%0d timeout", idx), 32'd1, 32'd0);
        @(negedge clk);
        req_load      = 1'b0;
        req_store     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        check32($sformatf("v%0d idle stall", idx), 32'(stall), 32'd0);
        check32($sformatf("v%0d idle valid", idx), 32'(mem_req_valid), 32'd0);
        check32($sformatf("v%0d idle fault", idx), 32'(lsu_fault), 32'd0);
    endtask

    initial begin
        //              ld st f3      addr          sdata         rdata         rdy rsp flt we wstrb  wdata         maddr         din           stall
        vecs.push_back('{1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0000_1000, 32'hFFFF_FF80, 3});
        vecs.push_back('{1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0000_2000, 32'h0000_BEEF, 3});
        vecs.push_back('{0, 1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0,        4, 0, 0, 1, 4'h2, 32'hA5A5_A5A5, 32'h0000_3000, 32'h0,        6});
        vecs.push_back('{1, 0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{1, 0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{1, 1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 1, 4'hF, 32'hDEAD_BEEF, 32'h0000_5000, 32'h0,        2});
        vecs.push_back('{1, 0, 3'b001, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 2, 0, 0, 0, 4'h0, 32'h0,        32'h0000_6000, 32'hFFFF_8001, 5});
        vecs.push_back('{1, 0, 3'b000, 32'h0000_7000, 32'h0,        32'h0000_007F, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0000_7000, 32'h0000_007F, 3});
        vecs.push_back('{1, 0, 3'b100, 32'h0000_7001, 32'h0,        32'h0000_C300, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0000_7000, 32'h0000_00C3, 3});
        vecs.push_back('{0, 1, 3'b001, 32'h0000_8002, 32'h1234_ABCD, 32'h0,        0, 0, 0, 1, 4'hC, 32'hABCD_ABCD, 32'h0000_8000, 32'h0,        2});
        vecs.push_back('{1, 0, 3'b001, 32'h0000_6001, 32'h0,        32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{0, 1, 3'b010, 32'h0000_9001, 32'h1111_2222, 32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{0, 1, 3'b100, 32'h0000_9000, 32'h1111_2222, 32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{1, 0, 3'b010, 32'h0000_A004, 32'h0,        32'h1357_9BDF, 0, 2, 0, 0, 4'h0, 32'h0,        32'h0000_A004, 32'h1357_9BDF, 5});
        vecs.push_back('{1, 0, 3'b101, 32'h0000_2000, 32'h0,        32'hBEEF_8001, 1, 0, 0, 0, 4'h0, 32'h0,        32'h0000_2000, 32'h0000_8001, 4});
        vecs.push_back('{0, 1, 3'b000, 32'h0000_3003, 32'h1234_565A, 32'h0,        0, 0, 0, 1, 4'h8, 32'h5A5A_5A5A, 32'h0000_3000, 32'h0,        2});

        reset         = 1'b1;
        req_load      = 1'b0;
        req_store     = 1'b0;
        funct3        = 3'b000;
        addr          = 32'h0;
        store_data    = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        din_model     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check32("rst D_in", D_in, 32'h0);
        check32("rst stall", 32'(stall), 32'd0);
        check32("rst fault", 32'(lsu_fault), 32'd0);
        check32("rst valid", 32'(mem_req_valid), 32'd0);
        check32("rst we", 32'(mem_we), 32'd0);
        check32("rst mem_addr", mem_addr, 32'h0);
        check32("rst wdata", mem_wdata, 32'h0);
        check32("rst wstrb", 32'(mem_wstrb), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset while a load waits for its response, then a stray response.
        @(negedge clk);
        req_load      = 1'b1;
        funct3        = 3'b000;
        addr          = 32'h0000_1003;
        mem_req_ready = 1'b1;
        #1;
        check32("rw idle stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check32("rw req valid", 32'(mem_req_valid), 32'd1);
        @(negedge clk);
        #1;
        check32("rw wait stall", 32'(stall), 32'd1);
        check32("rw wait valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        req_load      = 1'b0;
        mem_req_ready = 1'b0;
        din_model     = 32'h0;
        #1;
        check32("rw post stall", 32'(stall), 32'd0);
        check32("rw post valid", 32'(mem_req_valid), 32'd0);
        check32("rw post D_in", D_in, din_model);
        @(negedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        #1;
        check32("rw stray stall", 32'(stall), 32'd0);
        check32("rw stray valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        check32("rw stray D_in", D_in, din_model);
        check32("rw stray stall2", 32'(stall), 32'd0);

        // Reset in REQ drops mem_req_valid on the next edge.
        @(negedge clk);
        req_store  = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h0000_B000;
        store_data = 32'hCAFE_F00D;
        #1;
        @(negedge clk);
        #1;
        check32("rr req valid", 32'(mem_req_valid), 32'd1);
        reset     = 1'b1;
        req_store = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("rr post valid", 32'(mem_req_valid), 32'd0);
        check32("rr post stall", 32'(stall), 32'd0);

        // Recovery after reset.
        run_vec(100, '{1, 0, 3'b000, 32'h0000_7002, 32'h0, 32'h00FE_0000, 0, 0, 0, 0, 4'h0, 32'h0,
                       32'h0000_7000, 32'hFFFF_FFFE, 3});

        check32("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage between the ALU and the write-back select mux. It takes the ALU result as the effective address and RS2 as store data, and runs a valid/ready request to data memory. It stalls the single-cycle core until the access completes, then drives D_in, the aligned and sign- or zero-extended load value, to the write-back mux.

Parameters:
XLEN, 32, data/address width (only 32 supported)
MEM_AW, 32, memory address width (word-aligned address driven)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_load  in  1  current instruction is a load
req_store  in  1  current instruction is a store
funct3  in  3  access size/sign (RV32I encoding)
addr  in  32  effective address (ALU output)
store_data  in  32  RS2 value
D_in  out  32  extended load result to write-back mux
stall  out  1  hold PC/instruction while high
lsu_fault  out  1  one-cycle pulse: misaligned address or illegal funct3
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_AW  {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables (0 for reads)
mem_rsp_valid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; D_in, mem_addr, mem_wdata = 0; mem_wstrb = 0; mem_req_valid, mem_we, stall, lsu_fault = 0.
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE:
  - A request is req_load|req_store.
  - If both are high, the store wins.
  - If the request is legal and aligned: stall = 1 combinationally in the same cycle; latch addr, funct3, direction, wdata and wstrb; go to REQ.
  - If the request is illegal or misaligned: lsu_fault = 1 for that cycle, stall = 0, no memory access, stay IDLE.
  - mem_rsp_valid is ignored.
- REQ:
  - mem_req_valid = 1, with mem_addr/mem_we/mem_wdata/mem_wstrb held stable until mem_req_ready.
  - On ready: a store goes to DONE; a load goes to WAIT.
  - mem_rsp_valid is ignored; a response arrives no earlier than the cycle after acceptance.
- WAIT: on mem_rsp_valid, register the extracted value into D_in and go to DONE.
- DONE:
  - stall = 0 for exactly one cycle, and the core advances on this edge.
  - req_load/req_store are ignored, since they still reflect the finished instruction.
  - Next state is IDLE.
- stall is 1 in REQ and WAIT, and in IDLE when a legal request is present.
- Minimum latency: a load stalls 3 cycles and the core proceeds in cycle 4; a store stalls 2 cycles.
- Alignment:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Byte accesses are always aligned.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated into 4 lanes.
  - SH: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = halfword replicated into 2 lanes.
  - SW: wstrb = 4'b1111; wdata = store_data.
- Load extract:
  - Select the byte or halfword using the latched addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - D_in holds its last value until the next load completes; stores and faults leave it unchanged.
- Reset in any state: return to IDLE next edge and drop mem_req_valid. A stray mem_rsp_valid after reset is ignored and D_in is unchanged.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (2-bit IDLE/REQ/WAIT/DONE).
  - XLEN.
- Sub-module lsu_load_extract: combinational; inputs mem_rdata, addr[1:0], funct3; output the 32-bit extended value. The FSM, store-lane formatting and fault logic stay in the top module.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF_1234, ready and rsp immediate: stall high 3 cycles, then D_in=0xFFFF_FF80 and mem_addr=0x1000.
- LHU, addr=0x2002, mem_rdata=0xBEEF_0000: D_in=0x0000_BEEF.
- SB, addr=0x3001, store_data=0x0000_00A5, mem_req_ready low for 4 cycles: mem_req_valid/wstrb=0010/wdata=0xA5A5_A5A5 held stable; stall held until the cycle after ready; mem_we=1.
- LW, addr=0x4002 (misaligned): lsu_fault pulses 1 cycle, stall=0, no mem_req_valid, D_in unchanged; likewise funct3=011 load gives a fault.
- Reset asserted in WAIT, then mem_rsp_valid=1 with 0x1234_5678 two cycles later: state IDLE, stall=0, mem_req_valid=0, D_in keeps its prior value.
- req_load and req_store both high, SW, addr=0x5000: single write with wstrb=1111, no read issued.
